// File: rtl/fetch_stage.sv
// Instruction fetch stage: one outstanding instruction-memory request at a time,
// a one-entry skid buffer for stalls, and a drain state that discards stale data after a redirect.
module fetch_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [15:0] TruePC,
  output logic        IMemReq,
  output logic [15:0] IMemAddr,
  input  logic        IMemRdy,
  input  logic [15:0] IMemData,
  output logic [15:0] Instruct,
  output logic [15:0] NextPC,
  output logic        InstValid,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic [15:0] NOP = 16'h0800;

  state_t      state, state_n;
  logic [15:0] pc, pc_n;
  logic [15:0] instr_n, npc_n;
  logic        valid_n;
  logic [15:0] skid_data, skid_data_n;
  logic [15:0] skid_pc, skid_pc_n;
  logic [15:0] drain_addr, drain_addr_n;
  logic [15:0] pc_inc;

  assign pc_inc    = pc + 16'd1;
  assign fsm_state = state;

  // Memory handshake: a request is live while IMemReq=1 and completes on the
  // cycle IMemRdy=1; IMemAddr is stable for the whole request. IMemRdy is
  // meaningless while IMemReq=0 and is never sampled then.
  assign IMemReq  = (state == ISSUE) || (state == DRAIN);
  assign IMemAddr = (state == DRAIN) ? drain_addr : pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= BOOT;
      pc         <= 16'h0000;
      Instruct   <= NOP;
      NextPC     <= 16'h0000;
      InstValid  <= 1'b0;
      skid_data  <= NOP;
      skid_pc    <= 16'h0000;
      drain_addr <= 16'h0000;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      Instruct   <= instr_n;
      NextPC     <= npc_n;
      InstValid  <= valid_n;
      skid_data  <= skid_data_n;
      skid_pc    <= skid_pc_n;
      drain_addr <= drain_addr_n;
    end
  end

  always_comb begin
    state_n      = state;
    pc_n         = pc;
    instr_n      = Instruct;
    npc_n        = NextPC;
    valid_n      = InstValid;
    skid_data_n  = skid_data;
    skid_pc_n    = skid_pc;
    drain_addr_n = drain_addr;

    unique case (state)
      BOOT: begin
        state_n = ISSUE;
      end

      ISSUE: begin
        if (Stall) begin
          // Output register is frozen; a completed response parks in the skid.
          if (IMemRdy) begin
            skid_data_n = IMemData;
            skid_pc_n   = pc_inc;
            pc_n        = pc_inc;
            state_n     = HOLD;
          end
        end else if (Redirect) begin
          pc_n    = TruePC;
          instr_n = NOP;
          valid_n = 1'b0;
          if (!IMemRdy) begin
            drain_addr_n = pc;
            state_n      = DRAIN;
          end
        end else if (IMemRdy) begin
          instr_n = IMemData;
          npc_n   = pc_inc;
          valid_n = 1'b1;
          pc_n    = pc_inc;
        end else begin
          instr_n = NOP;
          valid_n = 1'b0;
        end
      end

      HOLD: begin
        if (!Stall) begin
          state_n     = ISSUE;
          skid_data_n = NOP;
          if (Redirect) begin
            pc_n    = TruePC;
            instr_n = NOP;
            valid_n = 1'b0;
          end else begin
            instr_n = skid_data;
            npc_n   = skid_pc;
            valid_n = 1'b1;
          end
        end
      end

      DRAIN: begin
        if (!Stall) begin
          instr_n = NOP;
          valid_n = 1'b0;
          if (Redirect) pc_n = TruePC;
        end
        // The stale response is dropped; the redirected PC is fetched next.
        if (IMemRdy) state_n = ISSUE;
      end

      default: state_n = BOOT;
    endcase
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: memory model returns addr+16'h1000 after a
// programmable wait, expected values are hand-computed constants.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        Stall;
  logic        Redirect;
  logic [15:0] TruePC;
  logic        IMemReq;
  logic [15:0] IMemAddr;
  logic        IMemRdy;
  logic [15:0] IMemData;
  logic [15:0] Instruct;
  logic [15:0] NextPC;
  logic        InstValid;
  logic [1:0]  fsm_state;

  int n_checks = 0;
  int n_fail   = 0;

  // memory model controls
  int   mem_wait = 0;
  logic mem_off  = 1'b0;
  int   wait_cnt = 0;

  localparam logic [1:0] S_BOOT = 2'd0, S_ISSUE = 2'd1, S_HOLD = 2'd2, S_DRAIN = 2'd3;

  fetch_stage dut (
    .clk       (clk),
    .rst       (rst),
    .Stall     (Stall),
    .Redirect  (Redirect),
    .TruePC    (TruePC),
    .IMemReq   (IMemReq),
    .IMemAddr  (IMemAddr),
    .IMemRdy   (IMemRdy),
    .IMemData  (IMemData),
    .Instruct  (Instruct),
    .NextPC    (NextPC),
    .InstValid (InstValid),
    .fsm_state (fsm_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory model
  always_comb begin
    IMemRdy  = IMemReq && !mem_off && (wait_cnt >= mem_wait);
    IMemData = IMemAddr + 16'h1000;
  end

  always @(posedge clk) begin
    if (rst || !IMemReq || IMemRdy) wait_cnt <= 0;
    else                            wait_cnt <= wait_cnt + 1;
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [15:0] ins, input logic [15:0] npc,
                           input logic vld);
    check({tag, ".instr"}, Instruct, ins);
    check({tag, ".npc"}, NextPC, npc);
    check({tag, ".valid"}, {15'd0, InstValid}, {15'd0, vld});
  endtask

  // reset then step out of BOOT; afterwards the DUT is in ISSUE with PC=0
  task automatic do_reset();
    rst = 1'b1; Stall = 1'b0; Redirect = 1'b0; TruePC = 16'h0000;
    mem_off = 1'b0;
    tick(); tick();
    check_out("rst", 16'h0800, 16'h0000, 1'b0);
    check("rst.req", {15'd0, IMemReq}, 16'd0);
    check("rst.state", {14'd0, fsm_state}, {14'd0, S_BOOT});
    rst = 1'b0;
    tick();
    check("boot.state", {14'd0, fsm_state}, {14'd0, S_ISSUE});
    check("boot.addr", IMemAddr, 16'h0000);
  endtask

  initial begin
    rst = 1'b1; Stall = 1'b0; Redirect = 1'b0; TruePC = 16'h0000;

    // zero-wait streaming
    mem_wait = 0;
    do_reset();
    check_out("boot.out", 16'h0800, 16'h0000, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_out("stream", 16'h1000 + 16'(i), 16'(i + 1), 1'b1);
    end

    // two-cycle latency: addr held, bubble between instructions
    mem_wait = 1;
    do_reset();
    tick();
    check_out("lat.b0", 16'h0800, 16'h0000, 1'b0);
    check("lat.addr0", IMemAddr, 16'h0000);
    tick();
    check_out("lat.v0", 16'h1000, 16'h0001, 1'b1);
    check("lat.addr1", IMemAddr, 16'h0001);
    tick();
    check_out("lat.b1", 16'h0800, 16'h0001, 1'b0);
    check("lat.addr1h", IMemAddr, 16'h0001);
    tick();
    check_out("lat.v1", 16'h1001, 16'h0002, 1'b1);

    // stall for three cycles with a response at PC=5
    mem_wait = 0;
    do_reset();
    repeat (5) tick();
    check_out("stl.pre", 16'h1004, 16'h0005, 1'b1);
    check("stl.addr", IMemAddr, 16'h0005);
    Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out("stl.frz", 16'h1004, 16'h0005, 1'b1);
      check("stl.req", {15'd0, IMemReq}, 16'd0);
      check("stl.state", {14'd0, fsm_state}, {14'd0, S_HOLD});
    end
    Stall = 1'b0;
    tick();
    check_out("stl.rel", 16'h1005, 16'h0006, 1'b1);
    check("stl.addr6", IMemAddr, 16'h0006);
    tick();
    check_out("stl.next", 16'h1006, 16'h0007, 1'b1);

    // redirect with response in the same cycle
    do_reset();
    tick();
    Redirect = 1'b1; TruePC = 16'h0040;
    tick();
    Redirect = 1'b0;
    check_out("rdr.bub", 16'h0800, 16'h0001, 1'b0);
    check("rdr.addr", IMemAddr, 16'h0040);
    tick();
    check_out("rdr.v", 16'h1040, 16'h0041, 1'b1);

    // redirect while request to 0x10 is outstanding
    do_reset();
    repeat (16) tick();
    check_out("drn.pre", 16'h100F, 16'h0010, 1'b1);
    mem_off = 1'b1;
    Redirect = 1'b1; TruePC = 16'h0080;
    tick();
    Redirect = 1'b0;
    check("drn.state", {14'd0, fsm_state}, {14'd0, S_DRAIN});
    check("drn.addr", IMemAddr, 16'h0010);
    check_out("drn.bub", 16'h0800, 16'h0010, 1'b0);
    tick();
    check("drn.addr2", IMemAddr, 16'h0010);
    check("drn.req", {15'd0, IMemReq}, 16'd1);
    mem_off = 1'b0;
    tick();
    check_out("drn.disc", 16'h0800, 16'h0010, 1'b0);
    check("drn.newaddr", IMemAddr, 16'h0080);
    tick();
    check_out("drn.v", 16'h1080, 16'h0081, 1'b1);

    // stall ignores redirect; redirect from HOLD discards skid
    do_reset();
    tick();
    Stall = 1'b1; Redirect = 1'b1; TruePC = 16'h0030;
    tick();
    check("hr.state", {14'd0, fsm_state}, {14'd0, S_HOLD});
    check_out("hr.frz", 16'h1000, 16'h0001, 1'b1);
    Stall = 1'b0; TruePC = 16'h0020;
    tick();
    Redirect = 1'b0;
    check_out("hr.bub", 16'h0800, 16'h0001, 1'b0);
    check("hr.addr", IMemAddr, 16'h0020);
    tick();
    check_out("hr.v", 16'h1020, 16'h0021, 1'b1);

    // PC wrap, then reset from DRAIN
    do_reset();
    Redirect = 1'b1; TruePC = 16'hFFFF;
    tick();
    Redirect = 1'b0;
    check("wrap.addr", IMemAddr, 16'hFFFF);
    tick();
    check_out("wrap.v", 16'h0FFF, 16'h0000, 1'b1);
    check("wrap.addr0", IMemAddr, 16'h0000);
    mem_off = 1'b1;
    Redirect = 1'b1; TruePC = 16'h1234;
    tick();
    Redirect = 1'b0;
    check("wrap.drain", {14'd0, fsm_state}, {14'd0, S_DRAIN});
    mem_off = 1'b0;
    rst = 1'b1;
    tick();
    check_out("drst", 16'h0800, 16'h0000, 1'b0);
    check("drst.req", {15'd0, IMemReq}, 16'd0);
    check("drst.state", {14'd0, fsm_state}, {14'd0, S_BOOT});
    rst = 1'b0;
    tick();
    check("drst.addr", IMemAddr, 16'h0000);
    tick();
    check_out("drst.v", 16'h1000, 16'h0001, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have port Stall  input  1  downstream decode stage cannot accept; hold outputs.
REQ-004 SHALL have port Redirect  input  1  taken branch/jump from decode.
REQ-005 SHALL have port TruePC  input  16  redirect target, sampled when Redirect=1.
REQ-006 SHALL have port IMemReq  output  1  instruction-memory request.
REQ-007 SHALL have port IMemAddr  output  16  word address of request.
REQ-008 SHALL have port IMemRdy  input  1  response valid; ends the request.
REQ-009 SHALL have port IMemData  input  16  instruction word, valid with IMemRdy.
REQ-010 SHALL have port Instruct  output  16  registered instruction to decode.
REQ-011 SHALL have port NextPC  output  16  registered PC of Instruct plus 1.
REQ-012 SHALL have port InstValid  output  1  Instruct is a real fetched instruction, not a bubble.

Function
REQ-013 PC SHALL be a 16-bit word address; increment is +1, modulo 2^16 (16'hFFFF wraps to 16'h0000).
REQ-014 NOP encoding SHALL be 16'h0800; a bubble is Instruct=16'h0800, InstValid=0, NextPC unchanged.
REQ-015 FSM states SHALL be BOOT, ISSUE, HOLD, DRAIN.
REQ-016 BOOT: entered on reset; IMemReq=0; unconditionally -> ISSUE next cycle.
REQ-017 ISSUE: IMemReq=1, IMemAddr=PC; IMemAddr SHALL stay constant while IMemReq=1 and IMemRdy=0.
REQ-018 ISSUE, IMemRdy=1, Stall=0, Redirect=0: output register <= {IMemData, PC+1, valid}; PC <= PC+1; stay ISSUE (zero-wait memory gives one instruction per cycle).
REQ-019 ISSUE, IMemRdy=0, Stall=0, Redirect=0: output register <= bubble; stay ISSUE.
REQ-020 Stall=1 (any state): output register SHALL hold; Redirect SHALL be ignored.
REQ-021 ISSUE, IMemRdy=1, Stall=1: capture {IMemData, PC+1} into one-entry skid buffer; PC <= PC+1; -> HOLD.
REQ-022 HOLD: IMemReq=0; when Stall=0, output register <= skid contents, skid cleared, -> ISSUE.
REQ-023 Redirect=1, Stall=0 in ISSUE with IMemRdy=1 or in HOLD: response/skid discarded; PC <= TruePC; output <= bubble; -> ISSUE.
REQ-024 Redirect=1, Stall=0 in ISSUE with IMemRdy=0 (request outstanding): PC <= TruePC; output <= bubble; -> DRAIN.
REQ-025 DRAIN: IMemReq=1 and IMemAddr held at the old outstanding address; on IMemRdy=1, data discarded, -> ISSUE (new PC requested next cycle); output stays bubble unless Stall=1.
REQ-026 Redirect in DRAIN SHALL update PC to the newest TruePC; remain DRAIN.
REQ-027 Exactly one request SHALL be outstanding at any time; IMemRdy while IMemReq=0 SHALL be ignored.

Reset
REQ-028 On rst=1 at a clock edge: PC=16'h0000, state=BOOT, Instruct=16'h0800, NextPC=16'h0000, InstValid=0, skid empty, IMemReq=0.
REQ-029 rst SHALL override all inputs, including mid-request or DRAIN; the pending response SHALL be dropped (IMemRdy ignored in BOOT).

Verification
REQ-030 Reset, zero-wait memory returning addr+16'h1000, Stall=0 -> BOOT 1 cycle, then Instruct=16'h1000,16'h1001,... NextPC=1,2,... InstValid=1 every cycle.
REQ-031 Memory 2-cycle latency -> IMemAddr held 2 cycles, one bubble (16'h0800, InstValid=0) between valid instructions.
REQ-032 Stall=1 for 3 cycles while IMemRdy=1 at PC=5 -> outputs frozen, HOLD with IMemReq=0, on release Instruct=mem[5], NextPC=6, then fetch PC=6.
REQ-033 Redirect=1, TruePC=16'h0040, IMemRdy=1 same cycle -> that data dropped, bubble output, next IMemAddr=16'h0040.
REQ-034 Redirect, TruePC=16'h0080, while request to 16'h0010 outstanding -> IMemAddr stays 16'h0010 until IMemRdy, data discarded, next IMemAddr=16'h0080, first valid NextPC=16'h0081.
REQ-035 PC=16'hFFFF fetched -> NextPC=16'h0000, next IMemAddr=16'h0000; rst asserted in DRAIN -> all REQ-028 values next cycle.
